// File: rtl/mem_stage_pkg.sv
// Shared widths, op codes, FSM encoding and alignment payload for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned SEL_W      = 4;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] wdata;
    logic [REG_W-1:0] ldata;
  } align_t;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] lo);
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return lo[0];
    if (op inside {EXE_LW_OP, EXE_SW_OP})             return |lo;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus req/ack interface between the MEM stage and the memory side.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic             req;
  logic             we;
  logic [REG_W-1:0] addr;
  logic [SEL_W-1:0] sel;
  logic [REG_W-1:0] wdata;
  logic             ack;
  logic [REG_W-1:0] rdata;

  modport master (output req, we, addr, sel, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane select, store replication and load extraction/extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [1:0]         i_addr_lo,
  input  logic [REG_W-1:0]   i_reg2,
  input  logic [REG_W-1:0]   i_rdata,
  output align_t             o_align
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    w_byte = i_rdata[31:24];
    case (i_addr_lo)
      2'b00: w_byte = i_rdata[31:24];
      2'b01: w_byte = i_rdata[23:16];
      2'b10: w_byte = i_rdata[15:8];
      2'b11: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_align = '0;
    case (i_aluop)
      EXE_LB_OP: begin
        o_align.sel   = 4'b1000 >> i_addr_lo;
        o_align.ldata = {{24{w_byte[7]}}, w_byte};
      end
      EXE_LBU_OP: begin
        o_align.sel   = 4'b1000 >> i_addr_lo;
        o_align.ldata = {24'b0, w_byte};
      end
      EXE_LH_OP: begin
        o_align.sel   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_align.ldata = {{16{w_half[15]}}, w_half};
      end
      EXE_LHU_OP: begin
        o_align.sel   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_align.ldata = {16'b0, w_half};
      end
      EXE_LW_OP: begin
        o_align.sel   = 4'b1111;
        o_align.ldata = i_rdata;
      end
      EXE_SB_OP: begin
        o_align.sel   = 4'b1000 >> i_addr_lo;
        o_align.wdata = {4{i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_align.sel   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_align.wdata = {2{i_reg2[15:0]}};
      end
      EXE_SW_OP: begin
        o_align.sel   = 4'b1111;
        o_align.wdata = i_reg2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: drives the data bus via req/ack, stalls until ack, formats load data for MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic                  whilo_i,
  input  logic [REG_W-1:0]      hi_i,
  input  logic [REG_W-1:0]      lo_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [REG_W-1:0]      mem_addr_i,
  input  logic [REG_W-1:0]      reg2_i,
  mem_stage_if.master           dbus,
  output logic                  stall_req_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  whilo_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  addr_err_o
);

  state_e           r_state;
  state_e           w_next_state;
  logic [REG_W-1:0] r_rdata_q;
  logic             w_latch;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_misaligned;
  align_t           w_align;

  assign w_is_load    = is_load(aluop_i);
  assign w_is_store   = is_store(aluop_i);
  assign w_misaligned = is_misaligned(aluop_i, mem_addr_i[1:0]);

  mem_align u_align (
    .i_aluop   (aluop_i),
    .i_addr_lo (mem_addr_i[1:0]),
    .i_reg2    (reg2_i),
    .i_rdata   (r_rdata_q),
    .o_align   (w_align)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) r_rdata_q <= dbus.rdata;
    end
  end

  // Next state and all outputs; reset forces every output low regardless of state.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    dbus.req     = 1'b0;
    dbus.we      = 1'b0;
    dbus.addr    = '0;
    dbus.sel     = '0;
    dbus.wdata   = '0;
    stall_req_o  = 1'b0;
    addr_err_o   = 1'b0;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    whilo_o      = whilo_i;
    hi_o         = hi_i;
    lo_o         = lo_i;

    case (r_state)
      ST_IDLE: begin
        if (w_is_load || w_is_store) begin
          wreg_o = 1'b0;
          if (w_misaligned) begin
            addr_err_o = 1'b1;
          end else begin
            dbus.req    = 1'b1;
            stall_req_o = 1'b1;
            if (dbus.ack) begin
              w_latch      = 1'b1;
              w_next_state = ST_DONE;
            end else begin
              w_next_state = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        wreg_o      = 1'b0;
        dbus.req    = 1'b1;
        stall_req_o = 1'b1;
        if (dbus.ack) begin
          w_latch      = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        if (w_is_load) begin
          wdata_o = w_align.ldata;
        end else if (w_is_store) begin
          wreg_o = 1'b0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Request fields are only meaningful while req is high.
    if (dbus.req) begin
      dbus.we    = w_is_store;
      dbus.addr  = {mem_addr_i[REG_W-1:2], 2'b00};
      dbus.sel   = w_align.sel;
      dbus.wdata = w_is_store ? w_align.wdata : '0;
    end

    if (rst) begin
      w_latch     = 1'b0;
      dbus.req    = 1'b0;
      dbus.we     = 1'b0;
      dbus.addr   = '0;
      dbus.sel    = '0;
      dbus.wdata  = '0;
      stall_req_o = 1'b0;
      addr_err_o  = 1'b0;
      wd_o        = NOP_REG_ADDR;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
    end
  end

endmodule
